// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB register-memory completer.
package apb_slave_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned APB_DW = 32;
    localparam int unsigned WCNT_W = 16;

    // Ceiling log2, floored at 1 so a single-word memory still gets an index bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB bus bundle between the bridge (master) and the memory completer (slave).
interface apb_slave_mem_if;
    import apb_slave_pkg::*;

    logic              Psel;
    logic              Penable;
    logic              Pwrite;
    logic [APB_DW-1:0] Paddr;
    logic [APB_DW-1:0] Pdata;
    logic              Pready;
    logic [APB_DW-1:0] Prdata;
    logic              Pslverr;

    modport master (
        output Psel, Penable, Pwrite, Paddr, Pdata,
        input  Pready, Prdata, Pslverr
    );

    modport slave (
        input  Psel, Penable, Pwrite, Paddr, Pdata,
        output Pready, Prdata, Pslverr
    );

endinterface

// File: rtl/apb_reg_array.sv
// DEPTH x 32 register file: synchronous write and clear, combinational read.
module apb_reg_array
    import apb_slave_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              rclk,
    input  logic              rrst,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [APB_DW-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [APB_DW-1:0] o_rdata
);

    logic [APB_DW-1:0] r_mem [DEPTH];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB completer with a word-addressed register memory, programmable wait states,
// out-of-range slave error and a saturating committed-write counter.
module apb_slave_mem
    import apb_slave_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned AW          = clog2(DEPTH),
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              rclk,
    input  logic              rrst,
    apb_slave_mem_if.slave    bus,
    output logic [WCNT_W-1:0] wr_count
);

    localparam logic [3:0] LP_CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_e              r_state;
    state_e              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic [AW-1:0]       r_idx;
    logic                r_write;
    logic                r_err;
    logic [APB_DW-1:0]   r_data;
    logic                r_pready;
    logic [APB_DW-1:0]   r_prdata;
    logic                r_pslverr;
    logic [WCNT_W-1:0]   r_wr_count;

    logic                w_setup;
    logic                w_access;
    logic                w_err_in;
    logic                w_latch;
    logic                w_we;
    logic                w_enter_done;
    logic                w_done_err;
    logic                w_done_wr;
    logic                w_pready_nxt;
    logic                w_pslverr_nxt;
    logic [APB_DW-1:0]   w_prdata_nxt;
    logic [WCNT_W-1:0]   w_wrc_nxt;
    logic [AW-1:0]       w_ridx;
    logic [APB_DW-1:0]   w_rdata;

    assign w_setup  = bus.Psel && !bus.Penable;
    assign w_access = bus.Psel && bus.Penable;
    assign w_err_in = (bus.Paddr >= DEPTH);

    // With zero wait states DONE is entered straight from the setup edge, so read the live address.
    assign w_ridx = (r_state == IDLE) ? bus.Paddr[AW-1:0] : r_idx;

    apb_reg_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_reg_array (
        .rclk    (rclk),
        .rrst    (rrst),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (r_data),
        .i_raddr (w_ridx),
        .o_rdata (w_rdata)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_latch       = 1'b0;
        w_we          = 1'b0;
        w_enter_done  = 1'b0;
        w_done_err    = r_err;
        w_done_wr     = r_write;
        w_wrc_nxt     = r_wr_count;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_prdata_nxt  = '0;

        unique case (r_state)
            IDLE: begin
                if (w_setup) begin
                    w_latch    = 1'b1;
                    w_done_err = w_err_in;
                    w_done_wr  = bus.Pwrite;
                    if (WAIT_STATES == 0) begin
                        w_state_nxt  = DONE;
                        w_enter_done = 1'b1;
                    end else begin
                        w_cnt_nxt   = LP_CNT_INIT;
                        w_state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!w_access) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_state_nxt  = DONE;
                    w_enter_done = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                if (w_access && r_write && !r_err) begin
                    w_we = 1'b1;
                    if (r_wr_count != '1) begin
                        w_wrc_nxt = r_wr_count + 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_enter_done) begin
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = w_done_err;
            w_prdata_nxt  = (!w_done_wr && !w_done_err) ? w_rdata : '0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_write    <= 1'b0;
            r_err      <= 1'b0;
            r_data     <= '0;
            r_pready   <= 1'b0;
            r_prdata   <= '0;
            r_pslverr  <= 1'b0;
            r_wr_count <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pready   <= w_pready_nxt;
            r_prdata   <= w_prdata_nxt;
            r_pslverr  <= w_pslverr_nxt;
            r_wr_count <= w_wrc_nxt;
            if (w_latch) begin
                r_idx   <= bus.Paddr[AW-1:0];
                r_write <= bus.Pwrite;
                r_err   <= w_err_in;
                r_data  <= bus.Pdata;
            end
        end
    end

    assign bus.Pready  = r_pready;
    assign bus.Prdata  = r_prdata;
    assign bus.Pslverr = r_pslverr;
    assign wr_count    = r_wr_count;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: three instances (0, 2 and 3 wait states) against a transfer-level model.
module tb_apb_slave_mem;

    logic        clk;
    logic        rrst;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pdata;
    int          sel;

    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [15:0] wrc;

    logic [15:0] wrc0, wrc2, wrc3;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Transfer-level model, indexed by wait-state count (0, 2, 3).
    logic [31:0] mem_m [4][16];
    int          wrc_m [4];

    apb_slave_mem_if if0 ();
    apb_slave_mem_if if2 ();
    apb_slave_mem_if if3 ();

    assign if0.Psel = psel && (sel == 0);
    assign if2.Psel = psel && (sel == 2);
    assign if3.Psel = psel && (sel == 3);
    assign if0.Penable = penable;
    assign if2.Penable = penable;
    assign if3.Penable = penable;
    assign if0.Pwrite = pwrite;
    assign if2.Pwrite = pwrite;
    assign if3.Pwrite = pwrite;
    assign if0.Paddr = paddr;
    assign if2.Paddr = paddr;
    assign if3.Paddr = paddr;
    assign if0.Pdata = pdata;
    assign if2.Pdata = pdata;
    assign if3.Pdata = pdata;

    assign pready  = (sel == 0) ? if0.Pready  : (sel == 2) ? if2.Pready  : if3.Pready;
    assign prdata  = (sel == 0) ? if0.Prdata  : (sel == 2) ? if2.Prdata  : if3.Prdata;
    assign pslverr = (sel == 0) ? if0.Pslverr : (sel == 2) ? if2.Pslverr : if3.Pslverr;
    assign wrc     = (sel == 0) ? wrc0        : (sel == 2) ? wrc2        : wrc3;

    apb_slave_mem #(.DEPTH(16), .AW(4), .WAIT_STATES(0)) u_dut0 (
        .rclk (clk), .rrst (rrst), .bus (if0), .wr_count (wrc0)
    );
    apb_slave_mem #(.DEPTH(16), .AW(4), .WAIT_STATES(2)) u_dut2 (
        .rclk (clk), .rrst (rrst), .bus (if2), .wr_count (wrc2)
    );
    apb_slave_mem #(.DEPTH(16), .AW(4), .WAIT_STATES(3)) u_dut3 (
        .rclk (clk), .rrst (rrst), .bus (if3), .wr_count (wrc3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_idle(input int n);
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic model_clear();
        for (int s = 0; s < 4; s++) begin
            wrc_m[s] = 0;
            for (int a = 0; a < 16; a++) mem_m[s][a] = '0;
        end
    endtask

    task automatic model_xfer(input int s, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, output logic [31:0] exp_rd,
                              output logic exp_err);
        exp_err = (addr >= 32'd16);
        exp_rd  = (!wr && !exp_err) ? mem_m[s][addr] : 32'h0;
        if (wr && !exp_err) begin
            mem_m[s][addr] = data;
            if (wrc_m[s] < 65535) wrc_m[s] = wrc_m[s] + 1;
        end
    endtask

    // Drives one full transfer from the setup cycle; returns the access cycle where Pready rose.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           output logic [31:0] rd, output logic err, output int lat);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pdata   = data;
        tick();
        penable = 1'b1;
        lat     = 0;
        rd      = '0;
        err     = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (pready === 1'b1) begin
                lat = c;
                rd  = prdata;
                err = pslverr;
                break;
            end
            tick();
        end
        if (lat != 0) tick();
    endtask

    task automatic apply_reset();
        psel    = 1'b0;
        penable = 1'b0;
        rrst    = 1'b1;
        tick();
        tick();
        rrst    = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pdata   = '0;
        rrst    = 1'b1;
        tick();
        tick();
        for (int k = 0; k < 3; k++) begin
            sel = (k == 0) ? 0 : (k == 1) ? 2 : 3;
            #1;
            n_cmp++;
            if (pready !== 1'b0 || pslverr !== 1'b0 || prdata !== 32'h0 || wrc !== 16'h0) begin
                n_fail++;
                $display("FAIL reset ws=%0d: got rdy=%b err=%b rd=%h wrc=%h want 0/0/0/0",
                         sel, pready, pslverr, prdata, wrc);
            end
        end
        rrst = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic test_basic();
        logic [31:0] rd;
        logic        err;
        int          lat;
        sel = 0;
        do_xfer(1'b1, 32'd0, 32'h1111_1111, rd, err, lat);
        n_cmp++;
        if (lat !== 1 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_write: got lat=%0d err=%b want lat=1 err=0", lat, err);
        end
        do_xfer(1'b0, 32'd0, 32'h0, rd, err, lat);
        n_cmp++;
        if (lat !== 1 || err !== 1'b0 || rd !== 32'h1111_1111) begin
            n_fail++;
            $display("FAIL basic_read: got lat=%0d err=%b rd=%h want 1/0/11111111", lat, err, rd);
        end
        bus_idle(1);
        n_cmp++;
        if (wrc !== 16'd1) begin
            n_fail++;
            $display("FAIL basic_wrcount: got %0d want 1", wrc);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          c0;
        int          nbad;
        apply_reset();
        sel  = 0;
        nbad = 0;
        c0   = cyc;
        for (int k = 1; k <= 15; k++) begin
            do_xfer(1'b1, 32'(k - 1), 32'h1111_1111 * 32'(k), rd, err, lat);
            if (lat != 1 || err !== 1'b0) nbad++;
        end
        n_cmp++;
        if (nbad != 0 || (cyc - c0) != 30) begin
            n_fail++;
            $display("FAIL b2b_writes: got bad=%0d cycles=%0d want bad=0 cycles=30", nbad, cyc - c0);
        end
        for (int k = 1; k <= 15; k++) begin
            do_xfer(1'b0, 32'(k - 1), 32'h0, rd, err, lat);
            n_cmp++;
            if (rd !== 32'h1111_1111 * 32'(k) || lat != 1 || err !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: got rd=%h lat=%0d err=%b want rd=%h lat=1 err=0",
                         k - 1, rd, lat, err, 32'h1111_1111 * 32'(k));
            end
            mem_m[0][k - 1] = 32'h1111_1111 * 32'(k);
        end
        wrc_m[0] = 15;
        bus_idle(1);
        n_cmp++;
        if (wrc !== 16'd15) begin
            n_fail++;
            $display("FAIL b2b_wrcount: got %0d want 15", wrc);
        end
    endtask

    task automatic test_wait3();
        logic [31:0] rd;
        logic        err;
        int          lat;
        sel = 3;
        do_xfer(1'b1, 32'd9, 32'hCAFE_0009, rd, err, lat);
        mem_m[3][9] = 32'hCAFE_0009;
        wrc_m[3]++;
        n_cmp++;
        if (lat != 4) begin
            n_fail++;
            $display("FAIL wait3_write_latency: got %0d want 4", lat);
        end
        do_xfer(1'b0, 32'd9, 32'h0, rd, err, lat);
        n_cmp++;
        if (lat != 4 || rd !== 32'hCAFE_0009 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait3_read: got lat=%0d rd=%h err=%b want 4/cafe0009/0", lat, rd, err);
        end
        bus_idle(1);
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd;
        logic        err;
        int          lat;
        logic [31:0] prior;
        sel   = 0;
        prior = mem_m[0][0];
        do_xfer(1'b1, 32'd16, 32'hDEAD_BEEF, rd, err, lat);
        n_cmp++;
        if (lat != 1 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_write: got lat=%0d err=%b want lat=1 err=1", lat, err);
        end
        do_xfer(1'b0, 32'd0, 32'h0, rd, err, lat);
        n_cmp++;
        if (rd !== prior || err !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_no_alias: got rd=%h err=%b want rd=%h err=0", rd, err, prior);
        end
        do_xfer(1'b0, 32'd40, 32'h0, rd, err, lat);
        n_cmp++;
        if (rd !== 32'h0 || err !== 1'b1 || lat != 1) begin
            n_fail++;
            $display("FAIL oor_read: got rd=%h err=%b lat=%0d want 0/1/1", rd, err, lat);
        end
        bus_idle(1);
        n_cmp++;
        if (wrc !== 16'(wrc_m[0])) begin
            n_fail++;
            $display("FAIL oor_wrcount: got %0d want %0d", wrc, wrc_m[0]);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          seen;
        sel     = 2;
        seen    = 0;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'd5;
        pdata   = 32'hA5A5_5A5A;
        tick();
        penable = 1'b1;
        if (pready === 1'b1) seen++;
        tick();
        psel = 1'b0;
        if (pready === 1'b1) seen++;
        tick();
        penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pready === 1'b1) seen++;
            tick();
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_ready: got %0d ready cycles want 0", seen);
        end
        n_cmp++;
        if (wrc !== 16'(wrc_m[2])) begin
            n_fail++;
            $display("FAIL abort_wrcount: got %0d want %0d", wrc, wrc_m[2]);
        end
        do_xfer(1'b0, 32'd5, 32'h0, rd, err, lat);
        n_cmp++;
        if (rd !== mem_m[2][5] || lat != 3 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_recover: got rd=%h lat=%0d err=%b want rd=%h lat=3 err=0",
                     rd, lat, err, mem_m[2][5]);
        end
        bus_idle(1);
    endtask

    task automatic test_random(input int s, input int n);
        logic [31:0] rd, exp_rd, addr, data;
        logic        err, exp_err, wr;
        int          lat;
        sel = s;
        for (int i = 0; i < n; i++) begin
            wr   = 1'($urandom_range(0, 1));
            addr = 32'($urandom_range(0, 19));
            if ($urandom_range(0, 7) == 0) addr = addr | 32'h1000_0000;
            data = $urandom;
            model_xfer(s, wr, addr, data, exp_rd, exp_err);
            do_xfer(wr, addr, data, rd, err, lat);
            n_cmp++;
            if (rd !== exp_rd || err !== exp_err || lat != s + 1) begin
                n_fail++;
                $display("FAIL rand ws=%0d #%0d wr=%b a=%h: got rd=%h err=%b lat=%0d want %h/%b/%0d",
                         s, i, wr, addr, rd, err, lat, exp_rd, exp_err, s + 1);
            end
            if ($urandom_range(0, 2) == 0) bus_idle($urandom_range(1, 2));
        end
        bus_idle(1);
        n_cmp++;
        if (wrc !== 16'(wrc_m[s])) begin
            n_fail++;
            $display("FAIL rand_wrcount ws=%0d: got %0d want %0d", s, wrc, wrc_m[s]);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          nbad;
        sel = 3;
        do_xfer(1'b1, 32'd7, 32'h7777_0007, rd, err, lat);
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = 1'b1;
        paddr   = 32'd3;
        pdata   = 32'h3333_3333;
        tick();
        penable = 1'b1;
        tick();
        rrst = 1'b1;
        tick();
        rrst    = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        model_clear();
        n_cmp++;
        if (pready !== 1'b0 || wrc !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset_state: got rdy=%b wrc=%0d want 0/0", pready, wrc);
        end
        tick();
        nbad = 0;
        for (int a = 0; a < 16; a++) begin
            do_xfer(1'b0, 32'(a), 32'h0, rd, err, lat);
            if (rd !== 32'h0 || err !== 1'b0 || lat != 4) nbad++;
        end
        n_cmp++;
        if (nbad != 0) begin
            n_fail++;
            $display("FAIL midreset_clear: got %0d nonzero/bad words want 0", nbad);
        end
        bus_idle(1);
    endtask

    initial begin
        sel = 0;
        model_clear();
        test_reset();
        test_basic();
        test_back_to_back();
        test_wait3();
        test_out_of_range();
        test_random(0, 40);
        test_random(2, 30);
        test_abort();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
